// File: rtl/dmem_arbiter.sv
// Two-master data memory arbiter (CPU = m0, display scanner = m1) with round-robin
// tie-break, bounded lock ownership and one-cycle read response routing.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed m0 priority with the lock logic removed.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk_74a,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  logic       any_req;
  logic       win1;
  logic       issue;
  logic       win_we;
  logic [1:0] rvalid_reg;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Lock inputs have no effect in this build.
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;

  always_comb begin
    win1 = ~m0_req;
  end
`else
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic             last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_hold;
  logic             win_lock;

  always_comb begin
    lock_hold = (last_grant ? m1_lock : m0_lock) && (lock_cnt < CNT_W'(MAX_LOCK));
    if (m0_req && m1_req) begin
      win1 = lock_hold ? last_grant : ~last_grant;
    end else begin
      win1 = ~m0_req;
    end
    win_lock = win1 ? m1_lock : m0_lock;
  end

  // lock_cnt counts the grants in the current locked run, so the first locked
  // grant to a new owner loads 1 and ownership is capped at MAX_LOCK grants.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      last_grant <= 1'b1;
      lock_cnt   <= '0;
    end else if (any_req) begin
      last_grant <= win1;
      if (!win_lock) begin
        lock_cnt <= '0;
      end else if (win1 != last_grant) begin
        lock_cnt <= CNT_W'(1);
      end else if (lock_cnt < CNT_W'(MAX_LOCK)) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end
    end
  end
`endif

  assign any_req   = m0_req | m1_req;
  assign issue     = any_req & ~reset;
  assign win_we    = win1 ? m1_we : m0_we;
  assign m0_gnt    = issue & ~win1;
  assign m1_gnt    = issue & win1;
  assign mem_addr  = win1 ? m1_addr : m0_addr;
  assign mem_wdata = win1 ? m1_wdata : m0_wdata;
  assign mem_we    = issue & win_we;
  assign mem_re    = issue & ~win_we;

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      rvalid_reg <= 2'b00;
    end else begin
      rvalid_reg <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
    end
  end

  // Masking with reset drops a response already in flight when reset arrives.
  assign m0_rvalid = rvalid_reg[0] & ~reset;
  assign m1_rvalid = rvalid_reg[1] & ~reset;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small one-cycle-latency memory model.
module tb_dmem_arbiter;

  logic        clk_74a = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_model [256];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk_74a = ~clk_74a;

  dmem_arbiter #(.ADDR_W(32), .MAX_LOCK(16)) dut (
    .clk_74a(clk_74a), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk_74a) begin
    if (reset) begin
      mem_model[8'h10] <= 32'h1111_0010;
      mem_model[8'h20] <= 32'h2222_0020;
    end else if (mem_we) begin
      mem_model[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= mem_model[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_74a);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 32'h10; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 32'h20; m1_wdata = 0;
    mem_rdata = 0;
    cyc();
    cyc();
    // Requests during reset must be ignored
    m0_req = 1; m1_req = 1;
    #2;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    cyc();
    reset = 0; m0_req = 0; m1_req = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("idle_gnt", {m1_gnt, m0_gnt}, 0);
      check("idle_strobes", {mem_we, mem_re}, 0);
      cyc();
    end

    // Continuous tie without lock alternates, starting with m0
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 6; i++) begin
      #2;
      check("rr_m0_gnt", m0_gnt, (i % 2 == 0) ? 1 : 0);
      check("rr_m1_gnt", m1_gnt, (i % 2 == 1) ? 1 : 0);
      check("rr_mem_addr", mem_addr, (i % 2 == 1) ? 32'h20 : 32'h10);
      check("rr_mem_re", mem_re, 1);
      check("rr_m0_rvalid", m0_rvalid, (i % 2 == 1) ? 1 : 0);
      check("rr_m1_rvalid", m1_rvalid, (i > 0 && i % 2 == 0) ? 1 : 0);
      if (i > 0) check("rr_rdata", mem_rdata, (i % 2 == 1) ? 32'h1111_0010 : 32'h2222_0020);
      cyc();
    end
    m0_req = 0; m1_req = 0;
    #2;
    check("rr_tail_gnt", {m1_gnt, m0_gnt}, 0);
    check("rr_tail_m1_rvalid", m1_rvalid, 1);
    check("rr_tail_m1_rdata", m1_rdata, 32'h2222_0020);
    check("rr_tail_m0_rvalid", m0_rvalid, 0);

    // m0 write then m1 read of the same address
    cyc();
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hDEAD_BEEF;
    #2;
    check("wr_m0_gnt", m0_gnt, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_re", mem_re, 0);
    check("wr_mem_addr", mem_addr, 32'h40);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    m0_req = 0; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h40;
    #2;
    check("rd_m1_gnt", m1_gnt, 1);
    check("rd_mem_re", mem_re, 1);
    check("wr_no_m0_rvalid", m0_rvalid, 0);
    cyc();
    m1_req = 0; m1_addr = 32'h20;
    #2;
    check("rd_m1_rvalid", m1_rvalid, 1);
    check("rd_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    check("rd_no_m0_rvalid", m0_rvalid, 0);
    cyc();

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Fixed priority: m0 wins every tie
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 10; i++) begin
      #2;
      check("fp_m0_gnt", m0_gnt, 1);
      check("fp_m1_gnt", m1_gnt, 0);
      cyc();
    end
    m0_req = 0;
    #2;
    check("fp_m1_after", m1_gnt, 1);
    cyc();
    m1_req = 0;
    cyc();
`else
    // Locked m0 keeps 16 grants, hands one to m1, then takes ownership back
    m0_lock = 1; m0_req = 1; m1_req = 1;
    for (int i = 0; i < 40; i++) begin
      #2;
      check("lk_m1_gnt", m1_gnt, (i == 16 || i == 33) ? 1 : 0);
      check("lk_m0_gnt", m0_gnt, (i == 16 || i == 33) ? 0 : 1);
      cyc();
    end
    m0_lock = 0; m0_req = 0; m1_req = 0;
    cyc();
    // Without lock, a tie after an m0 grant now goes to m1
    m0_req = 1; m1_req = 1;
    #2;
    check("post_lock_tie_m1", m1_gnt, 1);
    cyc();
    m0_req = 0; m1_req = 0;
    cyc();
`endif

    // Reset right after an m1 read grant discards the response
    m1_req = 1;
    #2;
    check("rs_m1_gnt", m1_gnt, 1);
    cyc();
    m1_req = 0; reset = 1;
    #2;
    check("rs_m1_rvalid_in_reset", m1_rvalid, 0);
    cyc();
    reset = 0; m0_req = 1; m1_req = 1;
    #2;
    check("rs_m1_rvalid_after", m1_rvalid, 0);
    check("rs_tie_m0_gnt", m0_gnt, 1);
    check("rs_tie_m1_gnt", m1_gnt, 0);
    cyc();
    m0_req = 0; m1_req = 0;
    #2;
    check("rs_m0_rvalid", m0_rvalid, 1);
    check("rs_m0_rdata", m0_rdata, 32'h1111_0010);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
